// File: rtl/mem_ctrl.sv
// mem_ctrl: data-side memory controller answering the EX-stage memctrl request.
// Accepts one request, runs one req/ack transaction on the data bus and holds the
// pipeline (o_memctrl_stall) until the transaction completes. Load data comes back
// lane-aligned and sign/zero-extended; a bus error or a timeout gives a data abort.
//
// Ports
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_memctrl_*              request from EX (vld/wr/sign/size/addr/wdata)
//   o_memctrl_stall          freeze IF/ID/EX
//   o_memctrl_rdata/_vld     formatted load data and its 1-cycle valid pulse
//   o_memctrl_abort          1-cycle data abort pulse
//   o_bus_*                  req/we/addr/be/wdata towards the data bus
//   i_bus_ack/err/rdata      bus response (err wins over ack)
module mem_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_memctrl_vld,
  input  logic        i_memctrl_wr,
  input  logic        i_memctrl_sign,
  input  logic [1:0]  i_memctrl_size,
  input  logic [31:0] i_memctrl_addr,
  input  logic [31:0] i_memctrl_wdata,
  output logic        o_memctrl_stall,
  output logic [31:0] o_memctrl_rdata,
  output logic        o_memctrl_rdata_vld,
  output logic        o_memctrl_abort,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic        i_bus_err,
  input  logic [31:0] i_bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Last counter value before the forced abort; unused when the timeout is disabled.
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

  state_e           state_q, state_d;
  logic             wr_q, wr_d;
  logic             sign_q, sign_d;
  logic [1:0]       size_q, size_d;
  logic [1:0]       lane_q, lane_d;
  logic [29:0]      addr_hi_q, addr_hi_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rdata_vld_q, rdata_vld_d;
  logic             abort_q, abort_d;

  function automatic logic [3:0] store_be(input logic wr, input logic [1:0] size,
                                          input logic [1:0] a);
    logic [3:0] be;
    be = 4'b1111;
    if (wr) begin
      case (size)
        2'b00:   be = 4'b0001 << a;
        2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Word loads rotate right by the byte offset (ARMv4 unaligned LDR); a shift of
  // 32 yields zero, so the aligned case needs no special handling.
  function automatic logic [31:0] load_fmt(input logic [1:0] size, input logic sgn,
                                           input logic [1:0] a, input logic [31:0] r);
    logic [31:0] sh;
    logic [5:0]  amt;
    logic [31:0] f;
    amt = {1'b0, a, 3'b000};
    case (size)
      2'b00: begin
        sh = r >> amt;
        f  = {{24{sgn & sh[7]}}, sh[7:0]};
      end
      2'b01: begin
        sh = r >> {a[1], 4'b0000};
        f  = {{16{sgn & sh[15]}}, sh[15:0]};
      end
      default: begin
        sh = '0;
        f  = (r >> amt) | (r << (6'd32 - amt));
      end
    endcase
    return f;
  endfunction

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    sign_d      = sign_q;
    size_d      = size_q;
    lane_d      = lane_q;
    addr_hi_d   = addr_hi_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    rdata_vld_d = 1'b0;
    abort_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_memctrl_vld) begin
          wr_d      = i_memctrl_wr;
          sign_d    = i_memctrl_sign;
          size_d    = i_memctrl_size;
          lane_d    = i_memctrl_addr[1:0];
          addr_hi_d = i_memctrl_addr[31:2];
          be_d      = store_be(i_memctrl_wr, i_memctrl_size, i_memctrl_addr[1:0]);
          wdata_d   = store_wdata(i_memctrl_size, i_memctrl_wdata);
          cnt_d     = '0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (i_bus_err) begin
          abort_d = 1'b1;
          state_d = S_DONE;
        end else if (i_bus_ack) begin
          if (!wr_q) begin
            rdata_d     = load_fmt(size_q, sign_q, lane_q, i_bus_rdata);
            rdata_vld_d = 1'b1;
          end
          state_d = S_DONE;
        end else if ((TIMEOUT > 0) && (cnt_q == TO_LAST)) begin
          abort_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // Request inputs still show the finished request here, so they are ignored.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b0;
      sign_q      <= 1'b0;
      size_q      <= 2'b00;
      lane_q      <= 2'b00;
      addr_hi_q   <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      rdata_vld_q <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      sign_q      <= sign_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
      addr_hi_q   <= addr_hi_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      rdata_vld_q <= rdata_vld_d;
      abort_q     <= abort_d;
    end
  end

  // Stall rises in the accepting IDLE cycle itself so EX cannot advance past the request.
  assign o_memctrl_stall     = !i_rst && (((state_q == S_IDLE) && i_memctrl_vld) ||
                                          (state_q == S_REQ));
  assign o_memctrl_rdata     = rdata_q;
  assign o_memctrl_rdata_vld = rdata_vld_q;
  assign o_memctrl_abort     = abort_q;
  assign o_bus_req           = (state_q == S_REQ);
  assign o_bus_we            = wr_q;
  assign o_bus_addr          = {addr_hi_q, 2'b00};
  assign o_bus_be            = be_q;
  assign o_bus_wdata         = wdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld, wr, sgn;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_vld, abort;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        ack, err;
  logic [31:0] bus_rdata;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.TIMEOUT(TO), .TO_W(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_memctrl_vld(vld), .i_memctrl_wr(wr), .i_memctrl_sign(sgn),
    .i_memctrl_size(size), .i_memctrl_addr(addr), .i_memctrl_wdata(wdata),
    .o_memctrl_stall(stall), .o_memctrl_rdata(rdata),
    .o_memctrl_rdata_vld(rdata_vld), .o_memctrl_abort(abort),
    .o_bus_req(bus_req), .o_bus_we(bus_we), .o_bus_addr(bus_addr),
    .o_bus_be(bus_be), .o_bus_wdata(bus_wdata),
    .i_bus_ack(ack), .i_bus_err(err), .i_bus_rdata(bus_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sg,
                                         input logic [1:0] a, input logic [31:0] r);
    longint unsigned w;
    longint unsigned v;
    w = r;
    if (sz == 2'd0) begin
      v = (w >> (8 * a)) % 256;
      if (sg && v >= 128) v = v + 64'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (w >> (a >= 2 ? 16 : 0)) % 65536;
      if (sg && v >= 32768) v = v + 64'hFFFF_0000;
    end else begin
      v = ((w + (w << 32)) >> (8 * a)) % 64'h1_0000_0000;
    end
    return 32'(v);
  endfunction

  function automatic logic [3:0] m_be(input logic w, input logic [1:0] sz, input logic [1:0] a);
    if (!w || sz >= 2) return 4'd15;
    if (sz == 0) return 4'(1 << a);
    return (a >= 2) ? 4'd12 : 4'd3;
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 0) return (d % 256) * 32'h0101_0101;
    if (sz == 1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  // ---------------- transaction driver ----------------
  // Entered and left 1 time unit after a rising edge. ack_at = REQ cycle (1-based)
  // in which the bus answers; 0 = never answers.
  task automatic run_txn(input logic w, input logic sg, input logic [1:0] sz,
                         input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] rd,
                         input int ack_at, input logic er,
                         output int n_stall, output int n_vld, output int n_abort,
                         output logic [31:0] b_addr, output logic [3:0] b_be,
                         output logic [31:0] b_wd, output logic b_we,
                         output int unstable, output logic timed_out);
    int  rc;
    bit  done;
    n_stall = 0; n_vld = 0; n_abort = 0; unstable = 0; rc = 0; done = 0;
    b_addr = '0; b_be = '0; b_wd = '0; b_we = 1'b0;
    vld = 1'b1; wr = w; sgn = sg; size = sz; addr = ad; wdata = wd; bus_rdata = rd;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (stall) n_stall++;
      if (rdata_vld) n_vld++;
      if (abort) n_abort++;
      if (bus_req) begin
        rc++;
        if (rc == 1) begin
          b_addr = bus_addr; b_be = bus_be; b_wd = bus_wdata; b_we = bus_we;
        end else if (b_addr !== bus_addr || b_be !== bus_be || b_wd !== bus_wdata ||
                     b_we !== bus_we) begin
          unstable++;
        end
      end
      if (c > 0 && !stall) done = 1;
      ack = bus_req && (rc == ack_at);
      err = ack && er;
      @(posedge clk); #1;
      ack = 1'b0; err = 1'b0;
    end
    vld = 1'b0;
    timed_out = !done;
  endtask

  typedef struct {
    logic        wr; logic sg; logic [1:0] sz;
    logic [31:0] ad; logic [31:0] wd; logic [31:0] rd;
    int          ack_at; logic er;
    logic [31:0] e_addr; logic [3:0] e_be; logic [31:0] e_bwd;
    int          e_stall; int e_vld; int e_abort; logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[10];

  int          n_stall, n_vld, n_abort, unstable;
  logic [31:0] b_addr, b_wd;
  logic [3:0]  b_be;
  logic        b_we, tmo;

  initial begin
    vecs[0] = '{1'b0,1'b1,2'd0,32'h103,32'h0,32'h80FF_1234,1,1'b0, 32'h100,4'hF,32'h0,2,1,0,32'hFFFF_FF80};
    vecs[1] = '{1'b1,1'b0,2'd1,32'h202,32'hDEAD_BEEF,32'h0,5,1'b0, 32'h200,4'hC,32'hBEEF_BEEF,6,0,0,32'hFFFF_FF80};
    vecs[2] = '{1'b0,1'b0,2'd2,32'h301,32'h0,32'h4433_2211,1,1'b0, 32'h300,4'hF,32'h0,2,1,0,32'h1144_3322};
    vecs[3] = '{1'b0,1'b0,2'd1,32'h302,32'h0,32'h4433_2211,2,1'b0, 32'h300,4'hF,32'h0,3,1,0,32'h0000_4433};
    vecs[4] = '{1'b0,1'b0,2'd0,32'h0,32'h0,32'h1234_5678,1,1'b1, 32'h0,4'hF,32'h0,2,0,1,32'h0000_4433};
    vecs[5] = '{1'b0,1'b1,2'd2,32'h40,32'h0,32'h1234_5678,0,1'b0, 32'h40,4'hF,32'h0,1+TO,0,1,32'h0000_4433};
    vecs[6] = '{1'b1,1'b0,2'd0,32'h3,32'h0000_00A5,32'h0,1,1'b0, 32'h0,4'h8,32'hA5A5_A5A5,2,0,0,32'h0000_4433};
    vecs[7] = '{1'b1,1'b0,2'd3,32'h7,32'h1234_5678,32'h0,3,1'b0, 32'h4,4'hF,32'h1234_5678,4,0,0,32'h0000_4433};
    vecs[8] = '{1'b0,1'b1,2'd1,32'h0,32'h0,32'h0000_8001,1,1'b0, 32'h0,4'hF,32'h0,2,1,0,32'hFFFF_8001};
    vecs[9] = '{1'b0,1'b0,2'd0,32'h1,32'h0,32'h0000_F000,1,1'b0, 32'h0,4'hF,32'h0,2,1,0,32'h0000_00F0};

    rst = 1'b1; vld = 1'b1; wr = 1'b0; sgn = 1'b0; size = 2'd0; addr = 32'hFFFF_FFFF;
    wdata = 32'hFFFF_FFFF; ack = 1'b0; err = 1'b0; bus_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_we", 32'(bus_we), 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_be", 32'(bus_be), 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_vld_abort", {30'd0, rdata_vld, abort}, 32'd0);
    rst = 1'b0; vld = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].wr, vecs[i].sg, vecs[i].sz, vecs[i].ad, vecs[i].wd, vecs[i].rd,
              vecs[i].ack_at, vecs[i].er, n_stall, n_vld, n_abort, b_addr, b_be, b_wd, b_we,
              unstable, tmo);
      chk($sformatf("v%0d_done", i), 32'(tmo), 32'd0);
      chk($sformatf("v%0d_stall_cycles", i), 32'(n_stall), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d_rdata_vld", i), 32'(n_vld), 32'(vecs[i].e_vld));
      chk($sformatf("v%0d_abort", i), 32'(n_abort), 32'(vecs[i].e_abort));
      chk($sformatf("v%0d_bus_addr", i), b_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_bus_be", i), 32'(b_be), 32'(vecs[i].e_be));
      chk($sformatf("v%0d_bus_we", i), 32'(b_we), 32'(vecs[i].wr));
      if (vecs[i].wr) chk($sformatf("v%0d_bus_wdata", i), b_wd, vecs[i].e_bwd);
      chk($sformatf("v%0d_stable", i), 32'(unstable), 32'd0);
      chk($sformatf("v%0d_rdata", i), rdata, vecs[i].e_rdata);
    end

    // Back-to-back loads with vld held through DONE: exactly two bus transactions
    begin
      int reqs, vlds, stalls;
      reqs = 0; vlds = 0; stalls = 0;
      vld = 1'b1; wr = 1'b0; sgn = 1'b0; size = 2'd2; addr = 32'h10; bus_rdata = 32'hCAFE_0001;
      for (int c = 0; c < 6; c++) begin
        #1;
        if (bus_req) reqs++;
        if (rdata_vld) vlds++;
        if (stall) stalls++;
        ack = bus_req;
        @(posedge clk); #1;
        ack = 1'b0;
      end
      vld = 1'b0;
      chk("b2b_req_cycles", 32'(reqs), 32'd2);
      chk("b2b_rdata_vld", 32'(vlds), 32'd2);
      chk("b2b_stall_cycles", 32'(stalls), 32'd4);
      chk("b2b_rdata", rdata, 32'hCAFE_0001);
      @(posedge clk); #1;
    end

    // Reset in the 2nd REQ cycle, late ack afterwards
    vld = 1'b1; wr = 1'b0; sgn = 1'b0; size = 2'd2; addr = 32'h500; bus_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    #1 chk("rstmid_req1", 32'(bus_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1 chk("rstmid_stall_in_rst", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; vld = 1'b0; ack = 1'b1;
    #1;
    chk("rstmid_req_dropped", 32'(bus_req), 32'd0);
    chk("rstmid_addr", bus_addr, 32'd0);
    chk("rstmid_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    ack = 1'b0;
    #1;
    chk("late_ack_state", {29'd0, bus_req, stall, rdata_vld}, 32'd0);
    chk("late_ack_abort_rdata", {31'd0, abort} | rdata, 32'd0);
    @(posedge clk); #1;

    // Randomized transactions against the reference model
    begin
      logic [31:0] m_rdata;
      logic        w, sg, er;
      logic [1:0]  sz;
      logic [31:0] ad, wd, rd;
      int          aa, e_req;
      bit          e_abort;
      m_rdata = 32'd0;
      for (int i = 0; i < 40; i++) begin
        w  = 1'($urandom_range(0, 1));
        sg = 1'($urandom_range(0, 1));
        sz = 2'($urandom_range(0, 3));
        ad = $urandom; wd = $urandom; rd = $urandom;
        aa = $urandom_range(0, 5);
        if ($urandom_range(0, 4) == 0) aa = 0;
        er = (aa > 0) && ($urandom_range(0, 5) == 0);
        run_txn(w, sg, sz, ad, wd, rd, aa, er, n_stall, n_vld, n_abort, b_addr, b_be, b_wd,
                b_we, unstable, tmo);
        e_req   = (aa == 0) ? TO : aa;
        e_abort = (aa == 0) || er;
        if (!w && !e_abort) m_rdata = m_load(sz, sg, ad[1:0], rd);
        chk($sformatf("r%0d_done", i), 32'(tmo), 32'd0);
        chk($sformatf("r%0d_stall_cycles", i), 32'(n_stall), 32'(1 + e_req));
        chk($sformatf("r%0d_abort", i), 32'(n_abort), 32'(e_abort));
        chk($sformatf("r%0d_rdata_vld", i), 32'(n_vld), 32'(!w && !e_abort));
        chk($sformatf("r%0d_bus_addr", i), b_addr, ad - (ad % 4));
        chk($sformatf("r%0d_bus_be", i), 32'(b_be), 32'(m_be(w, sz, ad[1:0])));
        chk($sformatf("r%0d_bus_we", i), 32'(b_we), 32'(w));
        if (w) chk($sformatf("r%0d_bus_wdata", i), b_wd, m_wd(sz, wd));
        chk($sformatf("r%0d_stable", i), 32'(unstable), 32'd0);
        chk($sformatf("r%0d_rdata", i), rdata, m_rdata);
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
